// File: rtl/fact_ctrl.sv
// Control FSM for the 32-bit factorial datapath: sequences load/multiply/decrement until compare drops.
// Optional macro FACT_ERR_CHK_EN adds an operand range check (n > MAX_N) with an ERR terminal state.
module fact_ctrl #(
  parameter int N_W   = 4,
  parameter int MAX_N = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           Go,
  input  logic [N_W-1:0] n,
  input  logic           compare,
  output logic [N_W-1:0] n_out,
  output logic           SEL,
  output logic           LD_REG,
  output logic           LD_CNT,
  output logic           CNT_EN,
  output logic           OE_EN,
  output logic           Busy,
  output logic           Done,
  output logic           Error,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4
`ifdef FACT_ERR_CHK_EN
    , S_ERR = 3'd5
`endif
  } state_t;

  // Handshake: Go is a level request, accepted only in IDLE; a result is released by Go going low.
  state_t         state_q, state_d;
  logic [N_W-1:0] n_out_q, n_out_d;
  logic           sel_q, sel_d;
  logic           ld_reg_q, ld_reg_d;
  logic           ld_cnt_q, ld_cnt_d;
  logic           cnt_en_q, cnt_en_d;
  logic           oe_en_q, oe_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

`ifdef FACT_ERR_CHK_EN
  localparam logic [N_W:0] MAX_N_L = MAX_N[N_W:0];
  logic n_big;
  assign n_big = ({1'b0, n} > MAX_N_L);
`endif

  always_comb begin
    state_d = state_q;
    n_out_d = n_out_q;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          n_out_d = n;
          state_d = S_INIT;
`ifdef FACT_ERR_CHK_EN
          if (n_big) state_d = S_ERR;
`endif
        end
      end
      S_INIT:  state_d = S_CHECK;
      S_CHECK: state_d = compare ? S_MULT : S_DONE;
      S_MULT:  state_d = S_CHECK;
      S_DONE:  if (!Go) state_d = S_IDLE;
`ifdef FACT_ERR_CHK_EN
      S_ERR:   if (!Go) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    sel_d    = 1'b0;
    ld_reg_d = 1'b0;
    ld_cnt_d = 1'b0;
    cnt_en_d = 1'b0;
    oe_en_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_d)
      S_INIT: begin
        ld_cnt_d = 1'b1;
        ld_reg_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_CHECK: busy_d = 1'b1;
      S_MULT: begin
        ld_reg_d = 1'b1;
        sel_d    = 1'b1;
        cnt_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        oe_en_d = 1'b1;
      end
`ifdef FACT_ERR_CHK_EN
      S_ERR: begin
        done_d  = 1'b1;
        error_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_out_q  <= '0;
      sel_q    <= 1'b0;
      ld_reg_q <= 1'b0;
      ld_cnt_q <= 1'b0;
      cnt_en_q <= 1'b0;
      oe_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_out_q  <= n_out_d;
      sel_q    <= sel_d;
      ld_reg_q <= ld_reg_d;
      ld_cnt_q <= ld_cnt_d;
      cnt_en_q <= cnt_en_d;
      oe_en_q  <= oe_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign n_out     = n_out_q;
  assign SEL       = sel_q;
  assign LD_REG    = ld_reg_q;
  assign LD_CNT    = ld_cnt_q;
  assign CNT_EN    = cnt_en_q;
  assign OE_EN     = oe_en_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign state_dbg = state_q;
`ifdef FACT_ERR_CHK_EN
  assign Error = error_q;
`else
  logic unused_error;
  assign unused_error = error_q;
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: a behavioural factorial datapath closes the loop around the controller.
// Expected results and latencies are queued at Go and compared when Done rises.
module tb_fact_ctrl;
  localparam int N_W = 4;

  logic           clk;
  logic           rst_n;
  logic           Go;
  logic [N_W-1:0] n;
  logic           compare;
  logic [N_W-1:0] n_out;
  logic           SEL, LD_REG, LD_CNT, CNT_EN, OE_EN, Busy, Done, Error;
  logic [2:0]     state_dbg;

  fact_ctrl #(.N_W(N_W), .MAX_N(12)) dut (
    .clk(clk), .rst_n(rst_n), .Go(Go), .n(n), .compare(compare),
    .n_out(n_out), .SEL(SEL), .LD_REG(LD_REG), .LD_CNT(LD_CNT),
    .CNT_EN(CNT_EN), .OE_EN(OE_EN), .Busy(Busy), .Done(Done),
    .Error(Error), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath (no reset, like the real one)
  logic [31:0] dp_cnt = 32'd0;
  logic [31:0] dp_reg = 32'd0;
  logic [31:0] dp_out;
  always @(posedge clk) begin
    if (LD_CNT)      dp_cnt <= {{(32-N_W){1'b0}}, n_out};
    else if (CNT_EN) dp_cnt <= dp_cnt - 32'd1;
    if (LD_REG)      dp_reg <= SEL ? dp_reg * dp_cnt : 32'd1;
  end
  assign compare = (dp_cnt > 32'd1);
  assign dp_out  = OE_EN ? dp_reg : 32'd0;

  // scoreboard
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact(input int k);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= k; i++) r = r * 32'(i);
    return r;
  endfunction

  // driver: run one operation; optionally keep Go high through DONE before releasing
  task automatic run_op(input logic [N_W-1:0] nv, input bit hold);
    bit          err_exp, got, busy_ok, cnt_seen, ld_seen;
    int          cyc, lat_exp;
    logic [31:0] res_exp;
    err_exp = 1'b0;
`ifdef FACT_ERR_CHK_EN
    err_exp = (nv > 4'd12);
`endif
    exp_q.push_back(err_exp ? 32'd0 : fact(int'(nv)));
    lat_q.push_back(err_exp ? 0 : ((nv < 2) ? 2 : 2 * int'(nv)));
    @(negedge clk);
    n  = nv;
    Go = 1'b1;
    got = 0; busy_ok = 1; cnt_seen = 0; ld_seen = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);  // this negedge follows edge number cyc
      if (cyc == 1) n = N_W'($urandom_range(0, 15));
      if (CNT_EN) cnt_seen = 1;
      if (LD_CNT || LD_REG) ld_seen = 1;
      if (Done) begin got = 1; break; end
      if (!Busy) busy_ok = 0;
    end
    check($sformatf("done_seen n=%0d", nv), 32'(got), 32'd1);
    res_exp = exp_q.pop_front();
    lat_exp = lat_q.pop_front();
    check($sformatf("latency n=%0d", nv), 32'(cyc), 32'(lat_exp));
    check($sformatf("result n=%0d", nv), dp_out, res_exp);
    check($sformatf("oe_en n=%0d", nv), 32'(OE_EN), 32'(!err_exp));
    check($sformatf("error n=%0d", nv), 32'(Error), 32'(err_exp));
    check($sformatf("busy_at_done n=%0d", nv), 32'(Busy), 32'd0);
    check($sformatf("busy_between n=%0d", nv), 32'(busy_ok), 32'd1);
    check($sformatf("n_out n=%0d", nv), 32'(n_out), 32'(nv));
    if (nv < 2) check($sformatf("no_cnt_en n=%0d", nv), 32'(cnt_seen), 32'd0);
    if (err_exp) check($sformatf("no_ld n=%0d", nv), 32'(ld_seen), 32'd0);
    if (hold) begin
      repeat (3) @(negedge clk);
      check("hold_done", 32'(Done), 32'd1);
      check("hold_oe", 32'(OE_EN), 32'(!err_exp));
      check("hold_no_restart", 32'({LD_CNT, LD_REG, Busy}), 32'd0);
    end
    Go = 1'b0;
    @(negedge clk);
    check($sformatf("idle_outs n=%0d", nv),
          32'({SEL, LD_REG, LD_CNT, CNT_EN, OE_EN, Busy, Done, Error}), 32'd0);
    check($sformatf("n_out_hold n=%0d", nv), 32'(n_out), 32'(nv));
  endtask

  initial begin
    rst_n = 1'b0;
    Go    = 1'b0;
    n     = '0;
    #12;
    check("reset_outs", 32'({SEL, LD_REG, LD_CNT, CNT_EN, OE_EN, Busy, Done, Error}), 32'd0);
    check("reset_n_out", 32'(n_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd5, 1'b0);
    run_op(4'd0, 1'b0);
    run_op(4'd1, 1'b0);
    run_op(4'd12, 1'b0);
    run_op(4'd13, 1'b0);
    run_op(4'd6, 1'b1);
    run_op(4'd15, 1'b0);
    for (int i = 0; i < 4; i++) run_op(N_W'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

    // asynchronous reset in the middle of a multiply step
    @(negedge clk);
    n  = 4'd7;
    Go = 1'b1;
    repeat (3) @(posedge clk);  // edges 0..2: IDLE->INIT->CHECK->MULT
    #2;
    check("mult_reached", 32'(CNT_EN), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'({SEL, LD_REG, LD_CNT, CNT_EN, OE_EN, Busy, Done, Error}), 32'd0);
    check("async_reset_n_out", 32'(n_out), 32'd0);
    Go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd3, 1'b0);

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
